// File: rtl/spi_apb_master_fifo_if.sv
// rtl/spi_apb_master_fifo_if.sv - APB register-bus bundle for the SPI master
interface spi_apb_master_fifo_if;
  logic        Psel;
  logic        Penable;
  logic [31:0] Paddr;
  logic        Pwrite;
  logic [31:0] Pwdata;
  logic        Pready;
  logic [31:0] Prdata;

  modport master (output Psel, Penable, Paddr, Pwrite, Pwdata, input Pready, Prdata);
  modport slave  (input Psel, Penable, Paddr, Pwrite, Pwdata, output Pready, Prdata);
endinterface

// File: rtl/spi_apb_master_fifo.sv
// rtl/spi_apb_master_fifo.sv - APB-programmable SPI master with TX/RX FIFOs
module spi_apb_master_fifo #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int NUM_CS     = 2,
  parameter int DIV_W      = 8
) (
  input  logic                  Pclk,
  input  logic                  Preset,
  spi_apb_master_fifo_if.slave  apb,
  output logic [NUM_CS-1:0]     cs,
  output logic                  sclk,
  output logic                  mosi,
  input  logic                  miso
);
  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int CW   = AW + 1;
  localparam int CS_W = (NUM_CS > 1) ? $clog2(NUM_CS) : 1;
  localparam int TW   = $clog2(2 * DATA_W);
  localparam logic [31:0] CTRL_MASK = 32'hF | (((32'h1 << DIV_W) - 32'h1) << 8)
                                            | (((32'h1 << CS_W) - 32'h1) << 24);

  typedef enum logic [2:0] {IDLE, SETUP, XFER, HOLD, GAP} state_t;

  state_t               state_q, state_d;
  logic [31:0]          ctrl_q, ctrl_d;
  logic [DATA_W-1:0]    tx_mem_q [FIFO_DEPTH];
  logic [DATA_W-1:0]    tx_mem_d [FIFO_DEPTH];
  logic [DATA_W-1:0]    rx_mem_q [FIFO_DEPTH];
  logic [DATA_W-1:0]    rx_mem_d [FIFO_DEPTH];
  logic [AW-1:0]        tx_wp_q, tx_wp_d, tx_rp_q, tx_rp_d, rx_wp_q, rx_wp_d, rx_rp_q, rx_rp_d;
  logic [CW-1:0]        tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
  logic                 tx_ovf_q, tx_ovf_d, rx_ovf_q, rx_ovf_d;
  logic                 cpha_q, cpha_d, lsb_q, lsb_d;
  logic [DIV_W-1:0]     div_q, div_d, div_cnt_q, div_cnt_d;
  logic [TW-1:0]        tgl_cnt_q, tgl_cnt_d;
  logic [DATA_W-1:0]    tx_sh_q, tx_sh_d, rx_sh_q, rx_sh_d;
  logic [NUM_CS-1:0]    cs_q, cs_d;
  logic                 sclk_q, sclk_d, mosi_q, mosi_d;

  logic acc, wr, rd, tx_pop, tx_push, rx_pop, rx_push, half_end, sample_now;
  logic [DATA_W-1:0] tx_head;
  logic [31:0] status;
  logic unused_addr_bits;

  function automatic logic first_bit(input logic [DATA_W-1:0] v, input logic lsb);
    return lsb ? v[0] : v[DATA_W-1];
  endfunction

  function automatic logic [DATA_W-1:0] advance(input logic [DATA_W-1:0] v, input logic lsb);
    return lsb ? (v >> 1) : (v << 1);
  endfunction

  assign acc = apb.Psel & apb.Penable;
  assign wr  = acc & apb.Pwrite;
  assign rd  = acc & ~apb.Pwrite;
  assign unused_addr_bits = ^{apb.Paddr[31:4], apb.Paddr[1:0]};
  assign tx_head  = tx_mem_q[tx_rp_q];
  assign half_end = (div_cnt_q == div_q);
  assign status = {25'd0, rx_ovf_q, tx_ovf_q, state_q != IDLE,
                   rx_cnt_q == CW'(FIFO_DEPTH), rx_cnt_q == '0,
                   tx_cnt_q == CW'(FIFO_DEPTH), tx_cnt_q == '0};

  always_comb begin
    state_d = state_q;   ctrl_d = ctrl_q;
    tx_mem_d = tx_mem_q; rx_mem_d = rx_mem_q;
    tx_wp_d = tx_wp_q;   tx_rp_d = tx_rp_q;   rx_wp_d = rx_wp_q;   rx_rp_d = rx_rp_q;
    tx_cnt_d = tx_cnt_q; rx_cnt_d = rx_cnt_q;
    tx_ovf_d = tx_ovf_q; rx_ovf_d = rx_ovf_q;
    cpha_d = cpha_q;     lsb_d = lsb_q;       div_d = div_q;
    div_cnt_d = div_cnt_q; tgl_cnt_d = tgl_cnt_q;
    tx_sh_d = tx_sh_q;   rx_sh_d = rx_sh_q;
    cs_d = cs_q;         sclk_d = sclk_q;     mosi_d = mosi_q;
    tx_pop = 1'b0;       rx_push = 1'b0;      sample_now = 1'b0;

    case (state_q)
      IDLE: begin
        cs_d   = '1;
        sclk_d = ctrl_q[1];
        if (ctrl_q[2] && tx_cnt_q != '0) begin
          tx_pop    = 1'b1;
          cpha_d    = ctrl_q[0];
          sclk_d    = ctrl_q[1];
          lsb_d     = ctrl_q[3];
          div_d     = ctrl_q[8 +: DIV_W];
          cs_d      = ~(NUM_CS'(1) << ctrl_q[24 +: CS_W]);
          div_cnt_d = '0;
          state_d   = SETUP;
          // With CPHA=0 the first bit must be on mosi before the leading edge.
          if (!ctrl_q[0]) begin
            mosi_d  = first_bit(tx_head, ctrl_q[3]);
            tx_sh_d = advance(tx_head, ctrl_q[3]);
          end else begin
            tx_sh_d = tx_head;
          end
        end
      end
      default: begin
        if (!half_end) begin
          div_cnt_d = div_cnt_q + 1'b1;
        end else begin
          div_cnt_d = '0;
          case (state_q)
            SETUP: begin
              tgl_cnt_d = '0;
              state_d   = XFER;
            end
            XFER: begin
              sclk_d     = ~sclk_q;
              tgl_cnt_d  = tgl_cnt_q + 1'b1;
              sample_now = (~tgl_cnt_q[0]) != cpha_q;
              if (sample_now)
                rx_sh_d = lsb_q ? {miso, rx_sh_q[DATA_W-1:1]} : {rx_sh_q[DATA_W-2:0], miso};
              else if (tgl_cnt_q != TW'(2 * DATA_W - 1)) begin
                mosi_d  = first_bit(tx_sh_q, lsb_q);
                tx_sh_d = advance(tx_sh_q, lsb_q);
              end
              if (tgl_cnt_q == TW'(2 * DATA_W - 1)) state_d = HOLD;
            end
            HOLD: begin
              rx_push = 1'b1;
              cs_d    = '1;
              state_d = GAP;
            end
            default: state_d = IDLE;
          endcase
        end
      end
    endcase

    if (wr && apb.Paddr[3:2] == 2'd0) ctrl_d = apb.Pwdata & CTRL_MASK;
    if (wr && apb.Paddr[3:2] == 2'd1) begin
      if (apb.Pwdata[5]) tx_ovf_d = 1'b0;
      if (apb.Pwdata[6]) rx_ovf_d = 1'b0;
    end

    // A full FIFO still accepts a write on the edge where an entry leaves it.
    tx_push = wr && apb.Paddr[3:2] == 2'd2 && (tx_cnt_q != CW'(FIFO_DEPTH) || tx_pop);
    if (wr && apb.Paddr[3:2] == 2'd2 && !tx_push) tx_ovf_d = 1'b1;
    if (tx_push) begin
      tx_mem_d[tx_wp_q] = apb.Pwdata[DATA_W-1:0];
      tx_wp_d = tx_wp_q + 1'b1;
    end
    if (tx_pop) tx_rp_d = tx_rp_q + 1'b1;
    tx_cnt_d = tx_cnt_q + CW'(tx_push) - CW'(tx_pop);

    rx_pop = rd && apb.Paddr[3:2] == 2'd3 && rx_cnt_q != '0;
    if (rx_push) begin
      if (rx_cnt_q != CW'(FIFO_DEPTH) || rx_pop) begin
        rx_mem_d[rx_wp_q] = rx_sh_q;
        rx_wp_d = rx_wp_q + 1'b1;
      end else begin
        rx_push  = 1'b0;
        rx_ovf_d = 1'b1;
      end
    end
    if (rx_pop) rx_rp_d = rx_rp_q + 1'b1;
    rx_cnt_d = rx_cnt_q + CW'(rx_push) - CW'(rx_pop);
  end

  always_comb begin
    apb.Prdata = '0;
    if (rd) begin
      case (apb.Paddr[3:2])
        2'd0:    apb.Prdata = ctrl_q;
        2'd1:    apb.Prdata = status;
        2'd3:    apb.Prdata = (rx_cnt_q != '0) ? 32'(rx_mem_q[rx_rp_q]) : 32'd0;
        default: apb.Prdata = '0;
      endcase
    end
  end

  assign apb.Pready = acc;
  assign cs   = cs_q;
  assign sclk = sclk_q;
  assign mosi = mosi_q;

  always_ff @(posedge Pclk) begin
    tx_mem_q <= tx_mem_d;
    rx_mem_q <= rx_mem_d;
  end

  always_ff @(posedge Pclk) begin
    if (Preset) begin
      state_q <= IDLE;   ctrl_q <= '0;
      tx_wp_q <= '0;     tx_rp_q <= '0;     rx_wp_q <= '0;     rx_rp_q <= '0;
      tx_cnt_q <= '0;    rx_cnt_q <= '0;    tx_ovf_q <= 1'b0;  rx_ovf_q <= 1'b0;
      cpha_q <= 1'b0;    lsb_q <= 1'b0;     div_q <= '0;
      div_cnt_q <= '0;   tgl_cnt_q <= '0;   tx_sh_q <= '0;     rx_sh_q <= '0;
      cs_q <= '1;        sclk_q <= 1'b0;    mosi_q <= 1'b0;
    end else begin
      state_q <= state_d;   ctrl_q <= ctrl_d;
      tx_wp_q <= tx_wp_d;   tx_rp_q <= tx_rp_d;   rx_wp_q <= rx_wp_d;   rx_rp_q <= rx_rp_d;
      tx_cnt_q <= tx_cnt_d; rx_cnt_q <= rx_cnt_d; tx_ovf_q <= tx_ovf_d; rx_ovf_q <= rx_ovf_d;
      cpha_q <= cpha_d;     lsb_q <= lsb_d;       div_q <= div_d;
      div_cnt_q <= div_cnt_d; tgl_cnt_q <= tgl_cnt_d; tx_sh_q <= tx_sh_d; rx_sh_q <= rx_sh_d;
      cs_q <= cs_d;         sclk_q <= sclk_d;     mosi_q <= mosi_d;
    end
  end
endmodule

// File: doc/spi_apb_master_fifo.md
Name: spi_apb_master_fifo

Overview:
APB-programmable SPI master. It generalises the single-register SPI-over-APB block to a parametrised frame width, TX/RX FIFOs, multiple chip selects, all four CPOL/CPHA modes and LSB-first ordering. It sits on the peripheral APB bus and drives external SPI slaves through cs/sclk/mosi/miso.

Parameters:
DATA_W, 8, SPI frame width in bits (legal range 4..32).
FIFO_DEPTH, 4, entries in each of the TX and RX FIFOs (power of 2, at least 2).
NUM_CS, 2, number of active-low chip selects.
DIV_W, 8, width of the clock-divider field.

Ports:
Pclk  input  1  system clock; the only clock.
Preset  input  1  synchronous reset, active-high.
Psel  input  1  APB select.
Penable  input  1  APB enable (access phase).
Paddr  input  32  byte address; only [3:2] decoded.
Pwrite  input  1  1 = write.
Pwdata  input  32  write data.
Pready  output  1  APB ready.
Prdata  output  32  read data.
cs  output  NUM_CS  active-low chip selects.
sclk  output  1  SPI clock.
mosi  output  1  master out.
miso  input  1  master in.

Behaviour:
- Reset values (Preset=1 at a Pclk rising edge): Pready=0, Prdata=0, cs=all 1s, sclk=0, mosi=0. FIFOs are emptied, sticky flags are cleared, CTRL=0, FSM goes to IDLE. A reset mid-frame aborts the frame immediately; no RX push occurs.
- APB: zero wait states. Pready = Psel&Penable. Writes and RX pops commit on the Pclk edge where Psel&Penable=1. Prdata is combinational during a read access and 0 otherwise.
- Register map:
  - 0x0 CTRL (RW): [0]CPHA, [1]CPOL, [2]EN, [3]LSB_FIRST, [8+:DIV_W]CLK_DIV, [24+:log2(NUM_CS)]CS_SEL.
  - 0x4 STATUS: [0]tx_empty, [1]tx_full, [2]rx_empty, [3]rx_full, [4]busy, [5]tx_ovf, [6]rx_ovf. Bits 5 and 6 are write-1-to-clear; all other bits are read-only.
  - 0x8 TXDATA (WO): pushes Pwdata[DATA_W-1:0]. A push to a full FIFO is dropped and sets tx_ovf. Reads return 0.
  - 0xC RXDATA (RO): pops and returns the head entry, zero-extended. Reading an empty FIFO returns 0 and does not pop.
- sclk half period is CLK_DIV+1 Pclk cycles. sclk idles at CPOL.
- FSM:
  - IDLE: cs all high, sclk=CPOL. When EN=1 and TX is not empty, pop TX into the shift register, latch CPHA/CPOL/LSB_FIRST/CLK_DIV/CS_SEL, then go to SETUP. Writes to CTRL during a frame affect only the next frame.
  - SETUP: cs[CS_SEL]=0 for one half period. If CPHA=0, the first bit is driven on mosi on entry.
  - XFER: 2*DATA_W half periods; each half period ends with one sclk toggle.
    - CPHA=0: sample miso on odd toggles (leading edges); shift mosi on even toggles, except after the final toggle.
    - CPHA=1: shift mosi on odd toggles; sample on even toggles.
    - Bit order is MSB-first, or LSB-first when LSB_FIRST=1.
  - HOLD: one half period with cs still low and sclk at CPOL. On exit, push the received word to RX. If RX is full, discard the word and set rx_ovf.
  - GAP: cs all high for one half period, then go to IDLE. Back-to-back frames therefore restart with no extra delay beyond GAP.
- busy=1 in every state except IDLE.
- Clearing EN mid-frame completes the current frame; no further frames start.
- Simultaneous APB push and FSM pop on the same edge: both take effect, so the FIFO count is unchanged. The same rule applies to an APB RX pop coinciding with an FSM RX push.
- Frame latency in Pclk cycles from TX push to RX push: 1 (IDLE) + (CLK_DIV+1)*(2*DATA_W+2).

Test Plan:
- Mode 0, CLK_DIV=0, mosi looped to miso: write CTRL=0x4, then TXDATA=0x14 (20) -> exactly 8 sclk rising edges, cs[0] low for 18 Pclk cycles, mosi bit sequence 0,0,0,1,0,1,0,0. Reading RXDATA returns 0x14, and STATUS then reads rx_empty=1, busy=0.
- Mode 3, CLK_DIV=2, CS_SEL=1, loopback: CTRL=0x0100020F (CPHA=1, CPOL=1, EN=1, LSB_FIRST=1, CLK_DIV=2, CS_SEL=1), TXDATA=0x41 -> sclk idles high with a 3-cycle half period, cs=2'b01, mosi is LSB-first (1,0,0,0,0,0,1,0), and RXDATA=0x41.
- Overflow: with EN=0, write TXDATA 5 times (values 1 to 5) -> tx_full=1 and tx_ovf=1. Setting EN=1 yields 4 frames carrying 1 to 4. Writing STATUS=0x20 clears tx_ovf.
- RX overflow: with miso=1, run 5 frames without reading -> rx_full=1 and rx_ovf=1. Four reads each return 0xFF, and a fifth read returns 0.
- Mid-frame CTRL write: change CLK_DIV from 0 to 3 during frame 1 of 2 -> frame 1 keeps a 1-cycle half period and frame 2 uses a 4-cycle half period.
- Reset mid-XFER: assert Preset after 3 sclk edges -> on the next Pclk edge cs=all 1s, sclk=0, STATUS reads 0x5 (tx_empty and rx_empty), and no RX entry is present.
